// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response, decode handoff, redirect and fault.
// master = fetch_unit side, slave = memory/decoder side.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_encoding;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst_encoding, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_pc,
        output fetch_fault
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst_encoding, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_pc,
        input  fetch_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order response buffer, redirect flush.
// Define FETCH_MISALIGN_TRAP_EN to trap (fetch_fault + HALT) on redirects with redirect_pc[1:0] != 0.
//
// state | meaning
// BOOT  | first cycle out of reset, no requests
// RUN   | fetching
// HALT  | stopped after misaligned redirect, left only by reset (FETCH_MISALIGN_TRAP_EN only)
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 2;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [1:0] ST_HALT = 2'd2;
`endif

    logic [1:0]       state;
    logic [31:0]      pc;
    logic [31:0]      buf_data [FIFO_DEPTH];
    logic [31:0]      buf_pc   [FIFO_DEPTH];
    logic [31:0]      tag_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0] buf_rd;
    logic [PTR_W-1:0] buf_wr;
    logic [PTR_W-1:0] tag_rd;
    logic [PTR_W-1:0] tag_wr;
    logic [CNT_W-1:0] buf_cnt;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;

    logic             redirect;
    logic [31:0]      redirect_target;
    logic             inst_valid;
    logic             pop_req;
    logic             pop;
    logic             rsp_drop;
    logic             rsp_push;
    logic             req_valid;
    logic             req_fire;
    logic [CNT_W-1:0] occ_after_pop;
    logic [SUM_W-1:0] credit_used;

    assign redirect        = bus.redirect_valid;
    assign redirect_target = {bus.redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = redirect && (bus.redirect_pc[1:0] != 2'b00);
`else
    logic unused_redirect_lo;
    assign unused_redirect_lo = ^bus.redirect_pc[1:0];
`endif

    assign inst_valid = (buf_cnt != '0);
    assign pop_req    = inst_valid && bus.inst_ready;
    assign pop        = pop_req && !redirect;
    assign rsp_drop   = bus.imem_rsp_valid && (drop_cnt != '0);
    assign rsp_push   = bus.imem_rsp_valid && (drop_cnt == '0) && !redirect;

    // A head leaving this cycle frees its slot before any new response can land,
    // which is what lets depth 2 sustain one instruction per cycle.
    assign occ_after_pop = buf_cnt - CNT_W'(pop_req);
    assign credit_used   = SUM_W'(occ_after_pop) + SUM_W'(outstanding) + SUM_W'(drop_cnt);
    assign req_valid     = (state == ST_RUN) && !redirect && (credit_used < SUM_W'(FIFO_DEPTH));
    assign req_fire      = req_valid && bus.imem_req_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = inst_valid;
    assign bus.inst_encoding  = inst_valid ? buf_data[buf_rd] : '0;
    assign bus.inst_pc        = inst_valid ? buf_pc[buf_rd]   : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
                ST_RUN:  if (misaligned) state <= ST_HALT;
`endif
                default: state <= state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_target;
        end else if (req_fire) begin
            pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_push) begin
            buf_data[buf_wr] <= bus.imem_rsp_data;
            buf_pc[buf_wr]   <= tag_pc[tag_rd];
        end
        if (req_fire) begin
            tag_pc[tag_wr] <= pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_rd      <= '0;
            buf_wr      <= '0;
            buf_cnt     <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect) begin
            buf_rd      <= '0;
            buf_wr      <= '0;
            buf_cnt     <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            outstanding <= '0;
            // Every in-flight word, including one landing now, must be swallowed exactly once.
            drop_cnt    <= drop_cnt + outstanding - CNT_W'(bus.imem_rsp_valid);
        end else begin
            if (rsp_push) begin
                buf_wr <= buf_wr + 1'b1;
                tag_rd <= tag_rd + 1'b1;
            end
            if (pop) begin
                buf_rd <= buf_rd + 1'b1;
            end
            if (req_fire) begin
                tag_wr <= tag_wr + 1'b1;
            end
            buf_cnt     <= buf_cnt + CNT_W'(rsp_push) - CNT_W'(pop);
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_push);
            drop_cnt    <= drop_cnt - CNT_W'(rsp_drop);
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else if (misaligned) begin
            fault <= 1'b1;
        end
    end
    assign bus.fetch_fault = fault;
`else
    assign bus.fetch_fault = 1'b0;
`endif

`ifndef SYNTHESIS
    // A response is only legal when some request is still owed to us.
    rsp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_rsp_valid |-> (outstanding != '0 || drop_cnt != '0));
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: streaming, backpressure, redirects, reset, PC wrap.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if b1();
    fetch_unit_if b2();

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.master)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2.master)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mem_lat  = 1;
    int acc_cnt  = 0;
    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    logic        acc2 = 1'b0;
    logic [31:0] a2   = '0;

    // In-order memory returning the request address as data after mem_lat cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq_addr.delete();
            mq_due.delete();
        end else if (b1.imem_req_valid && b1.imem_req_ready) begin
            mq_addr.push_back(b1.imem_req_addr);
            mq_due.push_back(cyc + mem_lat);
            acc_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n || mq_addr.size() == 0 || mq_due[0] > cyc) begin
            b1.imem_rsp_valid = 1'b0;
        end else begin
            b1.imem_rsp_valid = 1'b1;
            b1.imem_rsp_data  = mq_addr.pop_front();
            void'(mq_due.pop_front());
        end
    end

    always @(negedge clk) begin
        acc2 = rst_n && b2.imem_req_valid && b2.imem_req_ready;
        a2   = b2.imem_req_addr;
    end

    always @(posedge clk) begin
        #1;
        b2.imem_rsp_valid = rst_n && acc2;
        b2.imem_rsp_data  = a2;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit rdy_inst, input int lat);
        rst_n                = 1'b0;
        b1.imem_req_ready    = 1'b1;
        b1.inst_ready        = rdy_inst;
        b1.redirect_valid    = 1'b0;
        b1.redirect_pc       = '0;
        b2.imem_req_ready    = 1'b1;
        b2.inst_ready        = 1'b1;
        b2.redirect_valid    = 1'b0;
        b2.redirect_pc       = '0;
        mem_lat              = lat;
        repeat (2) @(negedge clk);
        acc_cnt = 0;
        rst_n   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n             = 1'b0;
        b1.imem_req_ready = 1'b1;
        b1.inst_ready     = 1'b1;
        b1.redirect_valid = 1'b0;
        b1.redirect_pc    = '0;
        b2.imem_req_ready = 1'b1;
        b2.inst_ready     = 1'b1;
        b2.redirect_valid = 1'b0;
        b2.redirect_pc    = '0;
        mem_lat           = 1;
        repeat (3) @(negedge clk);
        checks++; if (b1.imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", b1.imem_req_valid); end
        checks++; if (b1.inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%b exp=0", b1.inst_valid); end
        checks++; if (b1.inst_encoding !== 32'h0) begin failures++; $display("FAIL reset_inst_encoding got=%h exp=0", b1.inst_encoding); end
        checks++; if (b1.inst_pc !== 32'h0) begin failures++; $display("FAIL reset_inst_pc got=%h exp=0", b1.inst_pc); end
        checks++; if (b1.fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fetch_fault got=%b exp=0", b1.fetch_fault); end
        rst_n = 1'b1;
        #1;
        checks++; if (b1.imem_req_valid !== 1'b0) begin failures++; $display("FAIL boot_no_req got=%b exp=0", b1.imem_req_valid); end
        @(negedge clk);
        checks++; if (b1.imem_req_valid !== 1'b1 || b1.imem_req_addr !== 32'h0) begin failures++; $display("FAIL first_req got valid=%b addr=%h exp valid=1 addr=00000000", b1.imem_req_valid, b1.imem_req_addr); end
    endtask

    task automatic test_stream();
        do_reset(1'b1, 1);
        @(negedge clk);
        @(negedge clk);
        checks++; if (b1.inst_valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid got=%b exp=0", b1.inst_valid); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (b1.inst_valid !== 1'b1 || b1.inst_pc !== 32'(4 * i) || b1.inst_encoding !== 32'(4 * i)) begin
                failures++;
                $display("FAIL stream_%0d got valid=%b pc=%h enc=%h exp valid=1 pc=enc=%h", i, b1.inst_valid, b1.inst_pc, b1.inst_encoding, 32'(4 * i));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0, 1);
        repeat (10) @(negedge clk);
        checks++; if (acc_cnt != 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", acc_cnt); end
        checks++; if (b1.imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_stopped got=%b exp=0", b1.imem_req_valid); end
        checks++; if (b1.inst_valid !== 1'b1 || b1.inst_pc !== 32'h0) begin failures++; $display("FAIL bp_head got valid=%b pc=%h exp valid=1 pc=00000000", b1.inst_valid, b1.inst_pc); end
        step();
        b1.inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (b1.inst_valid !== 1'b1 || b1.inst_pc !== 32'(4 * i)) begin
                failures++;
                $display("FAIL bp_resume_%0d got valid=%b pc=%h exp valid=1 pc=%h", i, b1.inst_valid, b1.inst_pc, 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_inflight();
        int n;
        do_reset(1'b1, 3);
        step();
        step();
        step();
        b1.redirect_valid = 1'b1;
        b1.redirect_pc    = 32'h0000_0100;
        step();
        b1.redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (b1.imem_req_addr !== 32'h100 || b1.inst_valid !== 1'b0) begin failures++; $display("FAIL redir_pc got addr=%h inst_valid=%b exp addr=00000100 inst_valid=0", b1.imem_req_addr, b1.inst_valid); end
        n = 0;
        while (!b1.inst_valid && n < 30) begin @(negedge clk); n++; end
        checks++; if (b1.inst_valid !== 1'b1 || b1.inst_pc !== 32'h100 || b1.inst_encoding !== 32'h100) begin failures++; $display("FAIL redir_first got valid=%b pc=%h enc=%h exp valid=1 pc=enc=00000100", b1.inst_valid, b1.inst_pc, b1.inst_encoding); end
        n = 0;
        do begin @(negedge clk); n++; end while (!b1.inst_valid && n < 30);
        checks++; if (b1.inst_valid !== 1'b1 || b1.inst_pc !== 32'h104) begin failures++; $display("FAIL redir_second got valid=%b pc=%h exp valid=1 pc=00000104", b1.inst_valid, b1.inst_pc); end
    endtask

    task automatic test_redirect_coincident();
        do_reset(1'b1, 1);
        repeat (6) step();
        b1.redirect_valid = 1'b1;
        b1.redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        checks++; if (b1.inst_valid !== 1'b1 || b1.imem_req_valid !== 1'b0) begin failures++; $display("FAIL coinc_setup got inst_valid=%b req_valid=%b exp inst_valid=1 req_valid=0", b1.inst_valid, b1.imem_req_valid); end
        step();
        b1.redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (b1.inst_valid !== 1'b0 || b1.imem_req_valid !== 1'b1 || b1.imem_req_addr !== 32'h200) begin failures++; $display("FAIL coinc_next got inst_valid=%b req_valid=%b addr=%h exp 0 1 00000200", b1.inst_valid, b1.imem_req_valid, b1.imem_req_addr); end
        @(negedge clk);
        checks++; if (b1.inst_valid !== 1'b0) begin failures++; $display("FAIL coinc_dropped got inst_valid=%b exp=0", b1.inst_valid); end
        @(negedge clk);
        checks++; if (b1.inst_valid !== 1'b1 || b1.inst_pc !== 32'h200) begin failures++; $display("FAIL coinc_target got valid=%b pc=%h exp valid=1 pc=00000200", b1.inst_valid, b1.inst_pc); end
    endtask

    task automatic test_misalign();
        int n;
        int snap;
        do_reset(1'b1, 1);
        repeat (5) step();
        b1.redirect_valid = 1'b1;
        b1.redirect_pc    = 32'h0000_0102;
        step();
        b1.redirect_valid = 1'b0;
        @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++; if (b1.fetch_fault !== 1'b1 || b1.imem_req_valid !== 1'b0) begin failures++; $display("FAIL trap_fault got fault=%b req_valid=%b exp fault=1 req_valid=0", b1.fetch_fault, b1.imem_req_valid); end
        snap = acc_cnt;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b1.imem_req_valid !== 1'b0 || b1.fetch_fault !== 1'b1) n++;
        end
        checks++; if (n != 0 || acc_cnt != snap) begin failures++; $display("FAIL trap_halt got bad_cycles=%0d new_accepts=%0d exp 0 0", n, acc_cnt - snap); end
`else
        checks++; if (b1.fetch_fault !== 1'b0 || b1.imem_req_valid !== 1'b1 || b1.imem_req_addr !== 32'h100) begin failures++; $display("FAIL misalign_off got fault=%b req_valid=%b addr=%h exp 0 1 00000100", b1.fetch_fault, b1.imem_req_valid, b1.imem_req_addr); end
        snap = 0;
        n = 0;
        while (!b1.inst_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (b1.inst_valid !== 1'b1 || b1.inst_pc !== 32'h100 || b1.fetch_fault !== 1'b0) begin failures++; $display("FAIL misalign_off_inst got valid=%b pc=%h fault=%b exp 1 00000100 0", b1.inst_valid, b1.inst_pc, b1.fetch_fault); end
`endif
    endtask

    task automatic test_reset_mid();
        int snap;
        do_reset(1'b1, 1);
        repeat (5) step();
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (b1.imem_req_valid !== 1'b0 || b1.inst_valid !== 1'b0 || b1.inst_pc !== 32'h0 || b1.imem_req_addr !== 32'h0) begin failures++; $display("FAIL midreset_async got req_valid=%b inst_valid=%b pc=%h addr=%h exp 0 0 0 0", b1.imem_req_valid, b1.inst_valid, b1.inst_pc, b1.imem_req_addr); end
        snap = acc_cnt;
        repeat (5) @(negedge clk);
        checks++; if (acc_cnt != snap) begin failures++; $display("FAIL midreset_no_req got new_accepts=%0d exp=0", acc_cnt - snap); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (b1.inst_valid !== 1'b1 || b1.inst_pc !== 32'h0) begin failures++; $display("FAIL midreset_restart got valid=%b pc=%h exp valid=1 pc=00000000", b1.inst_valid, b1.inst_pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] wexp [3];
        wexp[0] = 32'hFFFF_FFF8;
        wexp[1] = 32'hFFFF_FFFC;
        wexp[2] = 32'h0000_0000;
        do_reset(1'b1, 1);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (b2.inst_valid !== 1'b1 || b2.inst_pc !== wexp[i] || b2.inst_encoding !== wexp[i]) begin
                failures++;
                $display("FAIL wrap_%0d got valid=%b pc=%h enc=%h exp valid=1 pc=enc=%h", i, b2.inst_valid, b2.inst_pc, b2.inst_encoding, wexp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_coincident();
        test_misalign();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
